// File: rtl/mem_router_pkg.sv
// mem_router_pkg: shared types and constants for the memory request router.
//   state_e   - router FSM state encoding
//   CH_*      - default channel indices for the three standard targets
package mem_router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam int CH_INSTR = 0;
  localparam int CH_MMR   = 1;
  localparam int CH_STACK = 2;

endpackage

// File: rtl/mem_router_if.sv
// mem_router_if: bundle of the CPU-side request/response handshake and the
// flattened memory-side channel bus. Channel i occupies slice [i*W +: W].
//   master - the environment (CPU core plus memory targets)
//   slave  - the router itself
interface mem_router_if #(
  parameter int AW  = 12,
  parameter int DW  = 16,
  parameter int NCH = 3
);
  localparam int SW = $clog2(NCH);

  logic              req_valid;
  logic              req_ready;
  logic [SW-1:0]     req_sel;
  logic [AW-1:0]     req_addr;
  logic              req_we;
  logic [DW-1:0]     req_wdata;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [NCH-1:0]    ch_valid;
  logic [NCH*AW-1:0] ch_addr;
  logic              ch_we;
  logic [DW-1:0]     ch_wdata;
  logic [NCH-1:0]    ch_ack;
  logic [NCH*DW-1:0] ch_rdata;

  modport master (
    output req_valid, req_sel, req_addr, req_we, req_wdata, ch_ack, ch_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           ch_valid, ch_addr, ch_we, ch_wdata
  );

  modport slave (
    input  req_valid, req_sel, req_addr, req_we, req_wdata, ch_ack, ch_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           ch_valid, ch_addr, ch_we, ch_wdata
  );

endinterface

// File: rtl/mem_router_wdt.sv
// mem_router_wdt: acknowledge timeout counter.
//   clk, rst_n - clock and async active-low reset
//   clear      - hold the count at zero
//   run        - count one waiting cycle
//   expire     - high in the last permitted waiting cycle (count==TIMEOUT-1)
module mem_router_wdt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + CW'(1);
    end
  end

  assign expire = run && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_router.sv
// mem_router: forwards one CPU memory request to one of NCH channels, waits
// for that channel's ack (bounded by TIMEOUT cycles) and returns a single
// one-cycle response with read data or an error flag.
//   clk, rst_n - clock and async active-low reset
//   bus        - request/response handshake and channel bus (slave view)
//
// state | meaning
// IDLE  | ready for a request; all channel outputs quiet
// ISSUE | driving the selected channel, waiting for its ack or timeout
// RESP  | one-cycle response strobe, then back to IDLE
module mem_router
  import mem_router_pkg::*;
#(
  parameter int AW      = 12,
  parameter int DW      = 16,
  parameter int NCH     = 3,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_router_if.slave bus
);
  localparam int SW = $clog2(NCH);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_RESP  = RESP;

  logic [1:0]     state;
  logic [SW-1:0]  sel_q;
  logic [AW-1:0]  addr_q;
  logic           we_q;
  logic [DW-1:0]  wdata_q;
  logic [DW-1:0]  rdata_q;
  logic           err_q;

  logic           issue;
  logic [NCH-1:0] ch_hit;
  logic           ack_hit;
  logic [DW-1:0]  rdata_mux;
  logic           expire;

  assign issue = (state == ST_ISSUE);

  // Channel decode is driven only from registered state, so no input
  // reaches an output combinationally.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [SW-1:0] IDX = SW'(i);
    assign ch_hit[i] = issue && (sel_q == IDX);
    assign bus.ch_addr[i*AW +: AW] = ch_hit[i] ? addr_q : '0;
  end

  // Masking with ch_hit makes acks from unselected channels irrelevant.
  assign ack_hit = |(bus.ch_ack & ch_hit);

  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_hit[i]) rdata_mux = rdata_mux | bus.ch_rdata[i*DW +: DW];
    end
  end

  mem_router_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!issue),
    .run    (issue && !ack_hit),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            sel_q   <= bus.req_sel;
            addr_q  <= bus.req_addr;
            we_q    <= bus.req_we;
            wdata_q <= bus.req_wdata;
            rdata_q <= '0;
            if (int'(bus.req_sel) < NCH) begin
              err_q <= 1'b0;
              state <= ST_ISSUE;
            end else begin
              err_q <= 1'b1;
              state <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          // An ack in the expiry cycle takes priority over the timeout.
          if (ack_hit) begin
            rdata_q <= we_q ? '0 : rdata_mux;
            err_q   <= 1'b0;
            state   <= ST_RESP;
          end else if (expire) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_rdata = bus.rsp_valid ? rdata_q : '0;
  assign bus.rsp_err   = bus.rsp_valid && err_q;
  assign bus.ch_valid  = ch_hit;
  assign bus.ch_we     = issue && we_q;
  assign bus.ch_wdata  = issue ? wdata_q : '0;

endmodule

// File: tb/tb_mem_router.sv
// tb_mem_router: directed bench for mem_router (NCH=3, TIMEOUT=4) with a
// transaction-level reference model checked on every falling edge.
module tb_mem_router;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int NCH = 3;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_router_if #(.AW(AW), .DW(DW), .NCH(NCH)) bus ();

  mem_router #(.AW(AW), .DW(DW), .NCH(NCH), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time. A valid request drives its
  // channel for up to TO cycles; the cycle after ack (or the TO-th cycle)
  // carries the response. An invalid sel responds the cycle after accept.
  bit          m_busy = 0;
  bit          m_resp = 0;
  int          m_sel = 0;
  int          m_age = 0;
  logic [11:0] m_addr = '0;
  bit          m_we = 0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_rdata = '0;
  bit          m_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_resp = 0; m_age = 0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_busy) begin
      if (bus.ch_ack[m_sel]) begin
        m_busy = 0; m_resp = 1; m_err = 0;
        m_rdata = m_we ? 16'h0 : bus.ch_rdata[m_sel*DW +: DW];
      end else if (m_age == TO) begin
        m_busy = 0; m_resp = 1; m_err = 1; m_rdata = 16'h0;
      end else begin
        m_age++;
      end
    end else if (bus.req_valid) begin
      m_sel = int'(bus.req_sel);
      m_addr = bus.req_addr;
      m_we = bus.req_we;
      m_wdata = bus.req_wdata;
      if (m_sel >= NCH) begin
        m_resp = 1; m_err = 1; m_rdata = 16'h0;
      end else begin
        m_busy = 1; m_age = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [35:0] ea;
    logic [2:0]  ev;
    ev = m_busy ? 3'(1 << m_sel) : 3'b000;
    ea = m_busy ? (36'(m_addr) << (m_sel * AW)) : 36'h0;
    chk("m_req_ready", 64'(bus.req_ready), 64'(!(m_busy || m_resp)));
    chk("m_ch_valid",  64'(bus.ch_valid),  64'(ev));
    chk("m_ch_addr",   64'(bus.ch_addr),   64'(ea));
    chk("m_ch_we",     64'(bus.ch_we),     64'(m_busy && m_we));
    chk("m_ch_wdata",  64'(bus.ch_wdata),  64'(m_busy ? m_wdata : 16'h0));
    chk("m_rsp_valid", 64'(bus.rsp_valid), 64'(m_resp));
    chk("m_rsp_rdata", 64'(bus.rsp_rdata), 64'(m_resp ? m_rdata : 16'h0));
    chk("m_rsp_err",   64'(bus.rsp_err),   64'(m_resp && m_err));
  end

  task automatic req(input int sel, input logic [11:0] addr, input bit we, input logic [15:0] wd);
    bus.req_valid = 1'b1;
    bus.req_sel   = 2'(sel);
    bus.req_addr  = addr;
    bus.req_we    = we;
    bus.req_wdata = wd;
  endtask

  task automatic set_rdata(input int ch, input logic [15:0] d);
    bus.ch_rdata[ch*DW +: DW] = d;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, time %0t expected < 50000", $time);
    $fatal(1);
  end

  initial begin
    bus.req_valid = 0; bus.req_sel = '0; bus.req_addr = '0; bus.req_we = 0;
    bus.req_wdata = '0; bus.ch_ack = '0; bus.ch_rdata = '0;
    #1 rst_n = 1'b0;
    nxt();
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_ch_addr", 64'(bus.ch_addr), 64'd0);
    nxt();
    #2 rst_n = 1'b1;
    nxt();

    // Read on channel 1 with ack held high.
    req(1, 12'h0A5, 0, 16'h0); bus.ch_ack = 3'b010; set_rdata(1, 16'hBEEF);
    nxt(); bus.req_valid = 0;
    chk("t1_ch_valid", 64'(bus.ch_valid), 64'h2);
    chk("t1_ch_addr", 64'(bus.ch_addr), 64'h0000A5000);
    chk("t1_ready", 64'(bus.req_ready), 64'd0);
    nxt();
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t1_rdata", 64'(bus.rsp_rdata), 64'hBEEF);
    chk("t1_err", 64'(bus.rsp_err), 64'd0);
    bus.ch_ack = 3'b000;
    nxt();
    chk("t1_ready_after", 64'(bus.req_ready), 64'd1);

    // Write on channel 2, ack in cycle 3; read data on the bus must be ignored.
    req(2, 12'h3C3, 1, 16'h1234); set_rdata(2, 16'hDEAD);
    nxt(); bus.req_valid = 0;
    chk("t2_ch_valid", 64'(bus.ch_valid), 64'h4);
    chk("t2_ch_addr", 64'(bus.ch_addr), 64'h3C3000000);
    chk("t2_ch_we", 64'(bus.ch_we), 64'd1);
    chk("t2_ch_wdata", 64'(bus.ch_wdata), 64'h1234);
    nxt();
    nxt();
    chk("t2_ch_valid_c3", 64'(bus.ch_valid), 64'h4);
    bus.ch_ack = 3'b100;
    nxt();
    chk("t2_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t2_rdata", 64'(bus.rsp_rdata), 64'h0);
    chk("t2_err", 64'(bus.rsp_err), 64'd0);
    bus.ch_ack = 3'b000;
    nxt();

    // Timeout on channel 0: ch_valid for exactly TO cycles.
    req(0, 12'h111, 0, 16'h0);
    for (int c = 1; c <= TO; c++) begin
      nxt(); bus.req_valid = 0;
      chk("t3_ch_valid", 64'(bus.ch_valid), 64'h1);
      chk("t3_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    nxt();
    chk("t3_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t3_err", 64'(bus.rsp_err), 64'd1);
    chk("t3_rdata", 64'(bus.rsp_rdata), 64'h0);
    chk("t3_ch_valid_off", 64'(bus.ch_valid), 64'h0);
    nxt();
    chk("t3_ready", 64'(bus.req_ready), 64'd1);

    // Ack in the expiry cycle wins; stray ack from channel 1 ignored.
    req(0, 12'h7FF, 0, 16'h0); set_rdata(0, 16'h5A5A); set_rdata(1, 16'h1111);
    nxt(); bus.req_valid = 0; bus.ch_ack = 3'b010;
    chk("t4_ch_valid", 64'(bus.ch_valid), 64'h1);
    nxt();
    nxt();
    chk("t4_no_rsp", 64'(bus.rsp_valid), 64'd0);
    nxt();
    chk("t4_ch_valid_c4", 64'(bus.ch_valid), 64'h1);
    bus.ch_ack = 3'b001;
    nxt();
    chk("t4_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t4_err", 64'(bus.rsp_err), 64'd0);
    chk("t4_rdata", 64'(bus.rsp_rdata), 64'h5A5A);
    bus.ch_ack = 3'b000;
    nxt();

    // Invalid sel.
    req(3, 12'h222, 0, 16'h0);
    nxt(); bus.req_valid = 0;
    chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t5_err", 64'(bus.rsp_err), 64'd1);
    chk("t5_ch_valid", 64'(bus.ch_valid), 64'h0);
    nxt();
    chk("t5_ready", 64'(bus.req_ready), 64'd1);

    // Reset during ISSUE discards the access.
    req(1, 12'h0AB, 0, 16'h0);
    nxt(); bus.req_valid = 0;
    chk("t6_ch_valid", 64'(bus.ch_valid), 64'h2);
    nxt();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ch_valid", 64'(bus.ch_valid), 64'h0);
    chk("t6_rst_ch_addr", 64'(bus.ch_addr), 64'h0);
    chk("t6_rst_ready", 64'(bus.req_ready), 64'd1);
    chk("t6_rst_rsp", 64'(bus.rsp_valid), 64'd0);
    nxt();
    nxt();
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      nxt();
      chk("t6_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    req(2, 12'h0CD, 0, 16'h0); bus.ch_ack = 3'b100; set_rdata(2, 16'h0F0F);
    nxt(); bus.req_valid = 0;
    chk("t6_ch_valid2", 64'(bus.ch_valid), 64'h4);
    nxt();
    chk("t6_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t6_rdata", 64'(bus.rsp_rdata), 64'h0F0F);
    bus.ch_ack = 3'b000;
    nxt();
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
